sd_spi_block_reader: RTL and testbench



---
 rtl/sd_spi_block_reader.sv | 237 +++++++++++++++++++++++
 tb/tb_sd_spi_block_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_block_reader.sv
// SD card single-block reader (CMD17) over SPI mode 0.
// It sends the command, waits for R1 and the start token, and streams the
// 512 payload bytes out one strobe per byte. It then checks the CRC16 and
// ends the transfer with a one-cycle done pulse that carries a result code.
module sd_spi_block_reader #(
  parameter int HALF_PERIOD   = 2,
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] block_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [8:0]  byte_index,
  output logic        sd_cclk,
  output logic        sd_cmd,
  output logic        sd_cs,
  input  logic        sd_data0
);

  // state      | meaning
  // IDLE       | card deselected, waiting for start
  // SEND_CMD   | shifting out the 48-bit CMD17 frame
  // WAIT_R1    | polling bytes for the R1 response
  // WAIT_TOKEN | polling bytes for the 0xFE start token
  // READ_DATA  | receiving 512 payload bytes, running CRC16
  // READ_CRC   | receiving the 2 CRC bytes, high byte first
  // TRAIL      | card deselected, 8 extra clocks
  // DONE       | done pulse, result on err
  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, TRAIL, DONE
  } state_t;

  localparam int HPW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HPW-1:0] HP_LOAD = HPW'(HALF_PERIOD - 1);
  localparam int TMAX = (R1_TIMEOUT > TOKEN_TIMEOUT) ? R1_TIMEOUT : TOKEN_TIMEOUT;
  localparam int PW = $clog2(TMAX + 1);

  state_t          state;
  logic [HPW-1:0]  hp_cnt;
  logic [46:0]     cmd_sr;
  logic [5:0]      bit_cnt;
  logic [6:0]      rx_sr;
  logic [2:0]      rx_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [8:0]      byte_cnt;
  logic [15:0]     crc;
  logic [7:0]      crc_hi;

  logic       running, tick, rise, fall, byte_done;
  logic [7:0] rx_byte;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  assign running   = (state != IDLE) && (state != DONE);
  assign tick      = (hp_cnt == '0);
  assign rise      = running && tick && !sd_cclk;
  assign fall      = running && tick && sd_cclk;
  assign rx_byte   = {rx_sr, sd_data0};
  assign byte_done = rise && (rx_cnt == 3'd0);

  // Sequencer: clock generation, command shift-out, byte receive and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hp_cnt     <= HP_LOAD;
      cmd_sr     <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_cnt     <= 3'd7;
      poll_cnt   <= '0;
      byte_cnt   <= '0;
      crc        <= '0;
      crc_hi     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 3'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_index <= '0;
      sd_cclk    <= 1'b0;
      sd_cmd     <= 1'b1;
      sd_cs      <= 1'b1;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;

      if (running) begin
        if (tick) begin
          hp_cnt  <= HP_LOAD;
          sd_cclk <= ~sd_cclk;
        end else begin
          hp_cnt <= hp_cnt - 1'b1;
        end
      end

      if (rise) begin
        rx_sr  <= rx_byte[6:0];
        rx_cnt <= rx_cnt - 3'd1;
      end

      case (state)
        IDLE: begin
          sd_cs  <= 1'b1;
          sd_cmd <= 1'b1;
          if (start) begin
            // MSB of 0x51 is 0 and goes out before the first rising edge
            cmd_sr  <= {7'h51, block_addr, 8'hFF};
            sd_cmd  <= 1'b0;
            sd_cs   <= 1'b0;
            busy    <= 1'b1;
            err     <= 3'd0;
            bit_cnt <= 6'd47;
            hp_cnt  <= HP_LOAD;
            sd_cclk <= 1'b0;
            rx_cnt  <= 3'd7;
            state   <= SEND_CMD;
          end
        end

        SEND_CMD: begin
          if (fall) begin
            if (bit_cnt == 6'd0) begin
              sd_cmd   <= 1'b1;
              rx_cnt   <= 3'd7;
              poll_cnt <= PW'(R1_TIMEOUT - 1);
              state    <= WAIT_R1;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              sd_cmd  <= cmd_sr[46];
              cmd_sr  <= {cmd_sr[45:0], 1'b1};
            end
          end
        end

        WAIT_R1: begin
          if (byte_done) begin
            if (!rx_byte[7]) begin
              if (rx_byte == 8'h00) begin
                poll_cnt <= PW'(TOKEN_TIMEOUT - 1);
                state    <= WAIT_TOKEN;
              end else begin
                err     <= 3'd2;
                sd_cs   <= 1'b1;
                bit_cnt <= 6'd8;
                state   <= TRAIL;
              end
            end else if (poll_cnt == '0) begin
              err     <= 3'd1;
              sd_cs   <= 1'b1;
              bit_cnt <= 6'd8;
              state   <= TRAIL;
            end else begin
              poll_cnt <= poll_cnt - 1'b1;
            end
          end
        end

        WAIT_TOKEN: begin
          if (byte_done) begin
            if (rx_byte == 8'hFE) begin
              byte_cnt <= '0;
              crc      <= '0;
              state    <= READ_DATA;
            end else if (rx_byte[7:4] == 4'h0) begin
              err     <= 3'd4;
              sd_cs   <= 1'b1;
              bit_cnt <= 6'd8;
              state   <= TRAIL;
            end else if (poll_cnt == '0) begin
              err     <= 3'd3;
              sd_cs   <= 1'b1;
              bit_cnt <= 6'd8;
              state   <= TRAIL;
            end else begin
              poll_cnt <= poll_cnt - 1'b1;
            end
          end
        end

        READ_DATA: begin
          if (rise) crc <= crc_step(crc, sd_data0);
          if (byte_done) begin
            data_out   <= rx_byte;
            data_valid <= 1'b1;
            byte_index <= byte_cnt;
            if (byte_cnt == 9'd511) begin
              byte_cnt <= '0;
              state    <= READ_CRC;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
            end
          end
        end

        READ_CRC: begin
          if (byte_done) begin
            if (!byte_cnt[0]) begin
              crc_hi   <= rx_byte;
              byte_cnt <= 9'd1;
            end else begin
              err     <= ({crc_hi, rx_byte} == crc) ? 3'd0 : 3'd5;
              sd_cs   <= 1'b1;
              bit_cnt <= 6'd8;
              state   <= TRAIL;
            end
          end
        end

        TRAIL: begin
          // entered on a rising edge; finish after 8 full extra clocks
          sd_cmd <= 1'b1;
          if (rise) bit_cnt <= bit_cnt - 6'd1;
          if (fall && bit_cnt == 6'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_block_reader.sv
// Directed bench for sd_spi_block_reader with a behavioural SPI card model.
module tb_sd_spi_block_reader;

  localparam int R1_TO  = 8;
  localparam int TOK_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] block_addr = '0;
  logic        busy, done, data_valid, sd_cclk, sd_cmd, sd_cs;
  logic [2:0]  err;
  logic [7:0]  data_out;
  logic [8:0]  byte_index;
  logic        sd_data0 = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  sd_spi_block_reader #(
    .HALF_PERIOD(2), .R1_TIMEOUT(R1_TO), .TOKEN_TIMEOUT(TOK_TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .block_addr(block_addr),
    .busy(busy), .done(done), .err(err), .data_out(data_out),
    .data_valid(data_valid), .byte_index(byte_index),
    .sd_cclk(sd_cclk), .sd_cmd(sd_cmd), .sd_cs(sd_cs), .sd_data0(sd_data0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // card model: records the command, then streams resp[] (0xFF beyond it)
  logic [7:0]  resp [0:519];
  int          resp_len = 0;
  logic [47:0] cmd_cap = '0;
  int          rise_cnt = 0, fall_cnt = 0, cs_rises = 0, trail_rises = 0;
  logic        prev_cs = 1'b1, prev_clk = 1'b0;
  int          k;
  logic [7:0]  cur;

  always @(sd_cclk or sd_cs) begin
    if (sd_cclk !== prev_clk) begin
      if (sd_cclk === 1'b1) begin
        if (prev_cs === 1'b0) begin
          if (rise_cnt < 48) cmd_cap = {cmd_cap[46:0], sd_cmd};
          rise_cnt++;
        end else begin
          trail_rises++;
        end
      end else if (prev_cs === 1'b0) begin
        fall_cnt++;
        if (fall_cnt >= 48) begin
          k = fall_cnt - 48;
          cur = (k / 8 < resp_len) ? resp[k / 8] : 8'hFF;
          sd_data0 = cur[7 - (k % 8)];
        end
      end
      prev_clk = sd_cclk;
    end
    if (sd_cs !== prev_cs) begin
      if (sd_cs === 1'b1) begin
        cs_rises    = rise_cnt;
        trail_rises = 0;
      end else begin
        rise_cnt = 0;
        fall_cnt = 0;
      end
      prev_cs = sd_cs;
    end
    if (sd_cs !== 1'b0) sd_data0 = 1'b1;
  end

  // output monitor: payload stream and done-cycle snapshot
  int   dv_cnt = 0, done_cnt = 0, trail_at_done = 0;
  logic [2:0] err_at_done = '0;
  logic busy_at_done = 1'b0, cs_at_done = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      chk("byte_index", 64'(byte_index), 64'(dv_cnt));
      chk("data_out", 64'(data_out), 64'(dv_cnt % 256));
      dv_cnt++;
    end
    if (done) begin
      done_cnt++;
      err_at_done   = err;
      busy_at_done  = busy;
      cs_at_done    = sd_cs;
      trail_at_done = trail_rises;
    end
  end

  function automatic logic [15:0] payload_crc();
    logic [15:0] c = 16'h0000;
    logic [7:0]  d;
    for (int i = 0; i < 512; i++) begin
      d = i[7:0];
      for (int b = 7; b >= 0; b--)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ d[b]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic load_good(input logic [7:0] flip);
    logic [15:0] c;
    c = payload_crc();
    resp[0] = 8'h00; resp[1] = 8'hFF; resp[2] = 8'hFF; resp[3] = 8'hFE;
    for (int i = 0; i < 512; i++) resp[4 + i] = i[7:0];
    resp[516] = c[15:8];
    resp[517] = c[7:0] ^ flip;
    resp_len = 518;
  endtask

  task automatic do_start(input logic [31:0] addr);
    @(negedge clk);
    dv_cnt = 0;
    block_addr = addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) @(negedge clk);
    chk(tag, 64'(done_cnt - n0), 64'd1);
  endtask

  initial begin
    int n0;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_cclk", 64'(sd_cclk), 64'd0);
    chk("rst_cmd", 64'(sd_cmd), 64'd1);
    chk("rst_cs", 64'(sd_cs), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of the payload
    load_good(8'h00);
    do_start(32'h0000_0001);
    for (int i = 0; i < 20000 && dv_cnt < 200; i++) @(negedge clk);
    chk("mid_reach_200", 64'(dv_cnt), 64'd200);
    n0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_dv", 64'(data_valid), 64'd0);
    chk("mid_data", 64'(data_out), 64'd0);
    chk("mid_index", 64'(byte_index), 64'd0);
    chk("mid_pins", 64'({sd_cclk, sd_cmd, sd_cs}), 64'b011);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", 64'(done_cnt), 64'(n0));

    // full good read; stray start and address change while busy
    do_start(32'h1234_5678);
    repeat (10) @(negedge clk);
    block_addr = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("good_done", 25000);
    chk("good_err", 64'(err_at_done), 64'd0);
    chk("good_count", 64'(dv_cnt), 64'd512);
    chk("good_cmd", 64'(cmd_cap), 64'h51_1234_5678_FF);
    chk("good_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("good_trail", 64'(trail_at_done), 64'd8);
    repeat (50) @(negedge clk);
    chk("no_restart", 64'(busy), 64'd0);
    chk("good_err_hold", 64'(err), 64'd0);

    // CRC mismatch
    load_good(8'h01);
    do_start(32'h0000_0200);
    wait_done("crc_done", 25000);
    chk("crc_err", 64'(err_at_done), 64'd5);
    chk("crc_count", 64'(dv_cnt), 64'd512);
    chk("crc_cmd", 64'(cmd_cap), 64'h51_0000_0200_FF);

    // R1 nonzero
    resp[0] = 8'h04; resp_len = 1;
    do_start(32'hA5A5_0F0F);
    wait_done("r1bad_done", 2000);
    chk("r1bad_err", 64'(err_at_done), 64'd2);
    chk("r1bad_count", 64'(dv_cnt), 64'd0);
    chk("r1bad_cs", 64'(cs_at_done), 64'd1);
    chk("r1bad_rises", 64'(cs_rises), 64'd56);
    repeat (20) @(negedge clk);
    chk("r1bad_err_hold", 64'(err), 64'd2);

    // R1 timeout: card stays 0xFF
    resp_len = 0;
    do_start(32'h0000_0000);
    wait_done("r1to_done", 3000);
    chk("r1to_err", 64'(err_at_done), 64'd1);
    chk("r1to_rises", 64'(cs_rises), 64'(48 + 8 * R1_TO));

    // error token
    resp[0] = 8'h00; resp[1] = 8'h09; resp_len = 2;
    do_start(32'h0000_0003);
    wait_done("etok_done", 2000);
    chk("etok_err", 64'(err_at_done), 64'd4);
    chk("etok_rises", 64'(cs_rises), 64'd64);

    // token timeout
    resp[0] = 8'h00; resp_len = 1;
    do_start(32'h0000_0004);
    wait_done("ttok_done", 4000);
    chk("ttok_err", 64'(err_at_done), 64'd3);
    chk("ttok_rises", 64'(cs_rises), 64'(48 + 8 * (1 + TOK_TO)));
    chk("ttok_count", 64'(dv_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
